// File: rtl/adsr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : adsr_pkg                                               |
// | Description : Shared types and constants for the ADSR envelope slice |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package adsr_pkg;

    // Envelope phases; 3-bit encoding is exported on state_o.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_e;

    localparam int         ENV_W_DEFAULT = 16;
    localparam logic [7:0] SAMPLE_ZERO   = 8'd128;

    // Offset-binary sample scaled by an 8-bit envelope:
    // 128 + ((smp - 128) * env) >>> 8. The result always fits 0..254,
    // so adding 128 back is a plain MSB flip of the shifted product.
    function automatic logic [7:0] scale_sample(input logic [7:0] smp,
                                                input logic [7:0] env);
        logic signed [8:0]  s;
        logic signed [17:0] p;
        s = $signed({1'b0, smp}) - 9'sd128;
        p = s * $signed({1'b0, env});
        return 8'(p >>> 8) ^ SAMPLE_ZERO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adsr_envelope_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : adsr_envelope_if                                       |
// | Description : Control, audio and status bundle of the ADSR envelope  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface adsr_envelope_if;
    import adsr_pkg::*;

    logic        gate_i;
    logic [7:0]  sample_data_i;
    logic [15:0] attack_i;
    logic [15:0] decay_i;
    logic [7:0]  sustain_i;
    logic [15:0] release_i;
    logic [7:0]  sample_data_o;
    logic [7:0]  env_o;
    adsr_state_e state_o;

    // Note/oscillator side: drives gate, rates and samples, observes the result.
    modport master (
        output gate_i, sample_data_i, attack_i, decay_i, sustain_i, release_i,
        input  sample_data_o, env_o, state_o
    );

    // Envelope block side.
    modport slave (
        input  gate_i, sample_data_i, attack_i, decay_i, sustain_i, release_i,
        output sample_data_o, env_o, state_o
    );
endinterface
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tick_divider                                           |
// | Description : Free-running prescaler, one-clk tick every TICK_DIV+1  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tick_divider #(
    parameter int TICK_DIV = 259
) (
    input  wire  clk,
    input  wire  rstn,
    output logic o_tick
);
    localparam int c_CNT_W = (TICK_DIV < 1) ? 1 : $clog2(TICK_DIV + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_wrap;

    assign w_wrap = (r_cnt == c_CNT_W'(TICK_DIV));
    assign o_tick = w_wrap;

    // Count 0..TICK_DIV and wrap; the tick is the cycle spent at TICK_DIV.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/adsr_envelope.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : adsr_envelope                                          |
// | Description : Gate-driven ADSR envelope scaling the FM sample stream |
// | Options     : ADSR_EXP_EN - exponential decay/release approach       |
// |               (step = max(1, (env - target) >> rate[3:0]))           |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int TICK_DIV = 259,
    parameter int ENV_W    = ENV_W_DEFAULT
) (
    input  wire             clk,
    input  wire             rstn,
    adsr_envelope_if.slave  bus
);
    localparam logic [ENV_W-1:0] c_ENV_MAX = '1;

    adsr_state_e      r_state;
    logic [ENV_W-1:0] r_env;
    logic [7:0]       r_sample;

    logic             w_tick;
    logic [ENV_W:0]   w_sum;
    logic             w_sat;
    logic [ENV_W-1:0] w_sus_lvl;
    logic [ENV_W-1:0] w_target;
    logic [15:0]      w_rate;
    logic             w_rate_zero;
    logic [ENV_W-1:0] w_diff;
    logic [ENV_W-1:0] w_step;
    logic             w_fall_done;
    logic [7:0]       w_env_top;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rstn   (rstn),
        .o_tick (w_tick)
    );

    assign w_env_top = r_env[ENV_W-1 -: 8];
    assign w_sus_lvl = {bus.sustain_i, {(ENV_W-8){1'b0}}};

    // Attack: widen by one bit so an overflowing add is seen and saturated.
    assign w_sum = {1'b0, r_env} + (ENV_W+1)'(bus.attack_i);
    assign w_sat = w_sum[ENV_W] || (w_sum[ENV_W-1:0] == c_ENV_MAX);

    // Decay and release share one falling-edge datapath toward a target level.
    assign w_target    = (r_state == ST_DECAY) ? w_sus_lvl : '0;
    assign w_rate      = (r_state == ST_DECAY) ? bus.decay_i : bus.release_i;
    assign w_rate_zero = (w_rate == 16'd0);
    assign w_diff      = r_env - w_target;
`ifdef ADSR_EXP_EN
    logic [ENV_W-1:0] w_shifted;
    assign w_shifted = w_diff >> w_rate[3:0];
    assign w_step    = (w_shifted == '0) ? ENV_W'(1) : w_shifted;
`else
    assign w_step    = ENV_W'(w_rate);
`endif
    // Clamp when already at/below target or when this step would reach it.
    assign w_fall_done = (r_env <= w_target) || (w_step >= w_diff);

    // ADSR state and envelope accumulator; gate changes take priority over ticks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_env   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.gate_i) r_state <= ST_ATTACK;
                end
                ST_ATTACK: begin
                    if (!bus.gate_i) begin
                        r_state <= ST_RELEASE;
                    end else if (w_tick && (bus.attack_i != 16'd0)) begin
                        if (w_sat) begin
                            r_env   <= c_ENV_MAX;
                            r_state <= ST_DECAY;
                        end else begin
                            r_env <= w_sum[ENV_W-1:0];
                        end
                    end
                end
                ST_DECAY: begin
                    if (!bus.gate_i) begin
                        r_state <= ST_RELEASE;
                    end else if (w_tick && !w_rate_zero) begin
                        if (w_fall_done) begin
                            r_env   <= w_target;
                            r_state <= ST_SUSTAIN;
                        end else begin
                            r_env <= r_env - w_step;
                        end
                    end
                end
                ST_SUSTAIN: begin
                    if (!bus.gate_i) begin
                        r_state <= ST_RELEASE;
                    end else if (w_tick) begin
                        r_env <= w_sus_lvl;
                    end
                end
                ST_RELEASE: begin
                    if (bus.gate_i) begin
                        r_state <= ST_ATTACK;
                    end else if (w_tick && !w_rate_zero) begin
                        if (w_fall_done) begin
                            r_env   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_env <= r_env - w_step;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_env   <= '0;
                end
            endcase
        end
    end

    // Audio scaler: one clk latency, updated every clk with the current envelope.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sample <= SAMPLE_ZERO;
        end else begin
            r_sample <= scale_sample(bus.sample_data_i, w_env_top);
        end
    end

    assign bus.sample_data_o = r_sample;
    assign bus.env_o         = w_env_top;
    assign bus.state_o       = r_state;
endmodule
`default_nettype wire

// File: tb/tb_adsr_envelope.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_adsr_envelope                                       |
// | Description : Directed self-checking bench for adsr_envelope         |
// |               (TICK_DIV=3: ticks land 4, 8, 12.. clks after reset)   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_adsr_envelope;
    import adsr_pkg::*;

    localparam int c_TICK_DIV = 3;
`ifdef ADSR_EXP_EN
    localparam logic [15:0] c_REL5 = 16'h0001;   // 0x8000 -> 0x4000 by halving
`else
    localparam logic [15:0] c_REL5 = 16'h4000;   // 0x8000 -> 0x4000 linearly
`endif

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_errors;

    adsr_envelope_if bus ();

    adsr_envelope #(
        .TICK_DIV (c_TICK_DIV),
        .ENV_W    (16)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #40 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_env(input string tag, input int env, input adsr_state_e st);
        check({tag, ".env"}, 32'(bus.env_o), 32'(env));
        check({tag, ".state"}, 32'(bus.state_o), 32'(st));
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int          exp_env;
        adsr_state_e exp_st;
        bit          seen;

        n_checks = 0;
        n_errors = 0;
        rstn              = 1'b0;
        bus.gate_i        = 1'b0;
        bus.sample_data_i = 8'd228;
        bus.attack_i      = 16'h0000;
        bus.decay_i       = 16'h0000;
        bus.sustain_i     = 8'h00;
        bus.release_i     = 16'h0000;

        // 1: reset held while the gate toggles
        for (int i = 0; i < 4; i++) begin
            nclk(1);
            bus.gate_i = i[0];
            nclk(1);
            check("rst.sample", 32'(bus.sample_data_o), 32'd128);
            check_env("rst", 0, ST_IDLE);
        end

        // release reset on a negedge; first tick edge is the 4th posedge after
        nclk(1);
        rstn          = 1'b1;
        bus.gate_i    = 1'b1;
        bus.attack_i  = 16'h4000;
        bus.decay_i   = 16'h1000;
        bus.sustain_i = 8'h80;
        bus.release_i = 16'h8000;

        // 2: attack 64,128,192 then saturate to 255 and enter DECAY
        nclk(1);
        check_env("att.start", 0, ST_ATTACK);
        nclk(3);
        check_env("att.t1", 64, ST_ATTACK);
        nclk(4);
        check_env("att.t2", 128, ST_ATTACK);
        nclk(4);
        check_env("att.t3", 192, ST_ATTACK);
        nclk(4);
        check_env("att.sat", 255, ST_DECAY);
        nclk(1);
        check("att.sample", 32'(bus.sample_data_o), 32'd227);

        // 3: decay to sustain level 0x80
        nclk(3);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) nclk(4);
`ifdef ADSR_EXP_EN
            exp_env = 128;
            exp_st  = ST_SUSTAIN;
`else
            exp_env = (k < 8) ? 255 - 16 * k : 128;
            exp_st  = (k < 8) ? ST_DECAY : ST_SUSTAIN;
`endif
            check_env($sformatf("dec.t%0d", k), exp_env, exp_st);
        end
        nclk(1);
        check("dec.sample", 32'(bus.sample_data_o), 32'd178);

        // sustain follows a changed level on the next tick
        bus.sustain_i = 8'h70;
        nclk(3);
        check_env("sus.track", 112, ST_SUSTAIN);
        bus.sustain_i = 8'h80;
        nclk(4);
        check_env("sus.back", 128, ST_SUSTAIN);

        // 4: gate off -> RELEASE, 128 -> 0 in one tick -> IDLE
        bus.gate_i = 1'b0;
        nclk(1);
        check_env("rel.enter", 128, ST_RELEASE);
        nclk(3);
        check_env("rel.done", 0, ST_IDLE);
        nclk(1);
        check("rel.sample", 32'(bus.sample_data_o), 32'd128);

        // 5: re-gate during RELEASE resumes attack from the current level
        bus.gate_i   = 1'b1;
        bus.attack_i = 16'h8000;
        nclk(3);
        check_env("re.att", 128, ST_ATTACK);
        bus.gate_i    = 1'b0;
        bus.release_i = c_REL5;
        nclk(1);
        check_env("re.rel", 128, ST_RELEASE);
        nclk(3);
        check_env("re.rel.t1", 64, ST_RELEASE);
        bus.gate_i   = 1'b1;
        bus.attack_i = 16'h1000;
        nclk(1);
        check_env("re.gate", 64, ST_ATTACK);
        nclk(3);
        check_env("re.att.t1", 80, ST_ATTACK);

        // zero attack rate holds the level and the state
        bus.attack_i = 16'h0000;
        nclk(4);
        check_env("hold0", 80, ST_ATTACK);

        // gate drop on the same clk as a tick: the gate transition wins
        bus.attack_i  = 16'h1000;
        bus.release_i = 16'h1000;
        nclk(3);
        bus.gate_i = 1'b0;
        nclk(1);
        check("gatewin.state", 32'(bus.state_o), 32'(ST_RELEASE));

        // release runs down to zero (bounded wait)
`ifdef ADSR_EXP_EN
        bus.release_i = 16'h0001;
`endif
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            nclk(1);
            if (bus.state_o == ST_IDLE) seen = 1'b1;
        end
        check("rel.reach_idle", 32'(seen), 32'd1);
        check_env("rel.final", 0, ST_IDLE);

        // reset mid-note returns immediately to reset values
        bus.gate_i   = 1'b1;
        bus.attack_i = 16'h4000;
        nclk(8);
        check("mid.env_nonzero", 32'(bus.env_o != 8'd0), 32'd1);
        rstn = 1'b0;
        #1;
        check_env("mid.rst", 0, ST_IDLE);
        check("mid.rst.sample", 32'(bus.sample_data_o), 32'd128);
        nclk(2);
        rstn = 1'b1;
        nclk(1);
        check_env("mid.regate", 0, ST_ATTACK);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
